stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Shares one shift stack (DEPTH entries of WIDTH bits, top-of-stack visible combinationally, one-cycle push/pop strobes) between two requesters.
- Arbitrates push/pop requests round-robin and tracks occupancy.
- Rejects overflow and underflow without touching the stack.
- Returns popped data and error status to the originating requester.
- Sits between the two client engines and the stack instance; stack and arbiter share clock and reset.

Parameters:
- WIDTH, 16, data width of stack entries and request/response data.
- DEPTH, 4, number of stack entries; must match the attached stack.
- CW, $clog2(DEPTH+1) = 3, width of the occupancy count (derived, not overridden).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_op  in  1  0 = push, 1 = pop.
- req0_data  in  WIDTH  push data (ignored for pop).
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_op, req1_data, req1_ready  same for requester 1.
- rsp0_valid  out  1  one-cycle response to requester 0.
- rsp0_data  out  WIDTH  popped value (0 for push or error).
- rsp0_error  out  1  op rejected (overflow/underflow).
- rsp1_valid, rsp1_data, rsp1_error  same for requester 1.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_write_data  out  WIDTH  data to stack.
- stk_read_data  in  WIDTH  stack top-of-stack.
- depth  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.

Behaviour:

Clocking and reset:
- Clock is clock. Reset is reset: synchronous, active-high.
- All state updates on posedge clock.
- Reset values:
  - FSM = IDLE, depth = 0, empty = 1, full = 0.
  - stk_push = stk_pop = 0, stk_write_data = 0.
  - All rsp*_valid/data/error = 0.
  - last_grant = 1, so requester 0 wins first.

FSM, two states:
- IDLE:
  - Arbitrate among valid requesters.
  - If only one is valid, grant it. If both are valid, grant the one != last_grant.
  - The granted reqN_ready is driven high combinationally in the same cycle; the other ready stays 0.
  - On the handshake edge, latch op, data and id; set last_grant = id; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly one cycle):
  - Registered stk_push or stk_pop is high for this cycle only, unless the op is an error.
  - stk_write_data holds the latched data for a push.
  - Both readies are 0.
  - At the end-of-cycle edge:
    - Capture stk_read_data as pop result; this is the pre-pop top.
    - Update depth (+1 push, -1 pop).
    - Assert the response registers; return to IDLE.

Error classification:
- Decided at accept time from the current depth.
- Push with depth == DEPTH is overflow; pop with depth == 0 is underflow.
- Error op: no stack strobe, depth unchanged, rsp_error = 1, rsp_data = 0.
- Error ops take the same latency as valid ops.

Latency and throughput:
- Accept at edge E.
- Stack strobe during cycle E+1.
- rspN_valid high for exactly one cycle, E+2, on the originating requester only. Data and error are valid in that same cycle; data and error return to 0 otherwise.
- Maximum throughput is one op per 2 cycles. The next accept may occur in the same cycle as the previous response.

Response rules:
- No response backpressure; requesters must sample rsp in the valid cycle.
- Push response: rsp_valid = 1, data 0, error 0.
- depth/empty/full are registered and reflect completed ops only.

Requester protocol:
- A requester holds valid/op/data stable until ready. The arbiter does not check this.
- Both requesters may have ops outstanding; each gets at most one accept per IDLE cycle.

Reset mid-operation:
- Reset asserted during EXEC abandons the op.
- No response is issued and strobes drop.
- The stack is cleared by the same reset, so depth = 0 is consistent.

Test Plan:
- Reset, then req0 push 0x1234 at cycle 1 -> req0_ready=1 in cycle 1; stk_push=1, stk_write_data=0x1234 in cycle 2; rsp0_valid=1, error 0 in cycle 3; depth=1.
- Push 0xA, 0xB, 0xC, 0xD from req1, then a 5th push 0xE -> 5th gets rsp1_error=1, no stk_push; full=1, depth=4.
- From full, req0 pops 4 times -> rsp0_data = 0xD, 0xC, 0xB, 0xA; empty=1; a 5th pop -> rsp0_error=1, rsp0_data=0, no stk_pop.
- req0 and req1 both hold valid continuously with pushes -> grants alternate 0,1,0,1; each response returns only to the granted requester; an accept every 2 cycles.
- After pushing 0x5555, req1 pops while req0 pushes 0x7777 in the same cycle, with last_grant=0 -> req1 granted first; rsp1_data=0x5555; req0 accepted 2 cycles later; final depth=1.
- Assert reset during the EXEC of a push -> no rsp*_valid, stk_push low the next cycle, depth=0, empty=1, next push proceeds normally.

Source files
------------

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one shift stack between two requesters.
// Tracks occupancy and rejects overflow/underflow without strobing the stack.
module stack_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_error,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_error,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_write_data,
    input  logic [WIDTH-1:0] stk_read_data,
    output logic [CW-1:0]    depth,
    output logic             empty,
    output logic             full
);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_err;

    logic             r_last_grant;
    logic             r_id;
    logic             r_op;
    logic             r_err;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_wdata;
    logic [CW-1:0]    r_depth;
    logic             r_rsp0_valid;
    logic [WIDTH-1:0] r_rsp0_data;
    logic             r_rsp0_error;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp1_data;
    logic             r_rsp1_error;

    always_comb begin
        w_next   = r_state;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On contention the requester not granted last time wins
                if (req0_valid && (!req1_valid || r_last_grant))
                    w_grant0 = 1'b1;
                else if (req1_valid)
                    w_grant1 = 1'b1;
                if (w_grant0 || w_grant1)
                    w_next = S_EXEC;
            end
            S_EXEC: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = w_grant0 | w_grant1;
    assign w_op     = w_grant1 ? req1_op : req0_op;
    assign w_data   = w_grant1 ? req1_data : req0_data;
    assign w_err    = w_op ? (r_depth == '0) : (r_depth == CW'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 1'b0;
            r_err        <= 1'b0;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_wdata      <= '0;
            r_depth      <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_error <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_error <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_error <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_error <= 1'b0;
            if (w_accept) begin
                r_last_grant <= w_grant1;
                r_id         <= w_grant1;
                r_op         <= w_op;
                r_err        <= w_err;
                r_push       <= !w_op && !w_err;
                r_pop        <= w_op && !w_err;
                r_wdata      <= (!w_op && !w_err) ? w_data : '0;
            end
            if (r_state == S_EXEC) begin
                // Top of stack is still the pre-pop value at this edge
                r_wdata <= '0;
                if (!r_id) begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_error <= r_err;
                    r_rsp0_data  <= (r_op && !r_err) ? stk_read_data : '0;
                end else begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_error <= r_err;
                    r_rsp1_data  <= (r_op && !r_err) ? stk_read_data : '0;
                end
                if (!r_err)
                    r_depth <= r_op ? r_depth - CW'(1) : r_depth + CW'(1);
            end
        end
    end

    assign req0_ready     = w_grant0;
    assign req1_ready     = w_grant1;
    assign stk_push       = r_push;
    assign stk_pop        = r_pop;
    assign stk_write_data = r_wdata;
    assign depth          = r_depth;
    assign empty          = (r_depth == '0);
    assign full           = (r_depth == CW'(DEPTH));
    assign rsp0_valid     = r_rsp0_valid;
    assign rsp0_data      = r_rsp0_data;
    assign rsp0_error     = r_rsp0_error;
    assign rsp1_valid     = r_rsp1_valid;
    assign rsp1_data      = r_rsp1_data;
    assign rsp1_error     = r_rsp1_error;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural shift stack attached.
module tb_stack_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0_valid, req0_op, req0_ready;
    logic             req1_valid, req1_op, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             rsp0_valid, rsp0_error, rsp1_valid, rsp1_error;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] stk_write_data, stk_read_data;
    logic [CW-1:0]    depth;
    logic             empty, full;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] stk [DEPTH];

    always #5 clock = ~clock;

    stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_error(rsp0_error),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_error(rsp1_error),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_write_data(stk_write_data), .stk_read_data(stk_read_data),
        .depth(depth), .empty(empty), .full(full)
    );

    // Shift stack model; entry 0 is the top
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (stk_push) begin
            for (int i = DEPTH - 1; i > 0; i--) stk[i] <= stk[i-1];
            stk[0] <= stk_write_data;
        end else if (stk_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
        end
    end
    assign stk_read_data = stk[0];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_op(input logic id, input logic op,
                         input logic [WIDTH-1:0] data,
                         input logic err, input logic [WIDTH-1:0] rd);
        @(negedge clock);
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_data = data;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = data;
        end
        #1;
        check("op_ready_own", id ? req1_ready : req0_ready, 1);
        check("op_ready_other", id ? req0_ready : req1_ready, 0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("op_exec_ready", {req0_ready, req1_ready}, 0);
        check("op_push", stk_push, !op && !err);
        check("op_pop", stk_pop, op && !err);
        if (!op && !err) check("op_wdata", stk_write_data, data);
        @(negedge clock);
        #1;
        check("op_rsp_valid", id ? rsp1_valid : rsp0_valid, 1);
        check("op_rsp_other", id ? rsp0_valid : rsp1_valid, 0);
        check("op_rsp_data", id ? rsp1_data : rsp0_data, rd);
        check("op_rsp_error", id ? rsp1_error : rsp0_error, err);
    endtask

    initial begin
        logic g;
        reset      = 1'b1;
        req0_valid = 1'b0; req0_op = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_data = '0;
        do_reset();
        #1;
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_strobes", {stk_push, stk_pop}, 0);
        check("rst_wdata", stk_write_data, 0);
        check("rst_rsp", {rsp0_valid, rsp0_error, rsp1_valid, rsp1_error}, 0);
        check("rst_rspdata", {rsp0_data, rsp1_data}, 0);

        do_op(1'b0, 1'b0, 16'h1234, 1'b0, 16'h0);
        check("t1_depth", depth, 1);

        do_reset();
        do_op(1'b1, 1'b0, 16'h000A, 1'b0, 16'h0);
        do_op(1'b1, 1'b0, 16'h000B, 1'b0, 16'h0);
        do_op(1'b1, 1'b0, 16'h000C, 1'b0, 16'h0);
        do_op(1'b1, 1'b0, 16'h000D, 1'b0, 16'h0);
        check("t2_full4", full, 1);
        do_op(1'b1, 1'b0, 16'h000E, 1'b1, 16'h0);
        check("t2_depth", depth, 4);
        check("t2_full", full, 1);

        do_op(1'b0, 1'b1, 16'h0, 1'b0, 16'h000D);
        do_op(1'b0, 1'b1, 16'h0, 1'b0, 16'h000C);
        do_op(1'b0, 1'b1, 16'h0, 1'b0, 16'h000B);
        do_op(1'b0, 1'b1, 16'h0, 1'b0, 16'h000A);
        check("t3_empty", empty, 1);
        check("t3_depth", depth, 0);
        do_op(1'b0, 1'b1, 16'h0, 1'b1, 16'h0);
        check("t3_depth_after_err", depth, 0);

        // Both requesters push continuously: grants must alternate
        do_reset();
        @(negedge clock);
        req0_valid = 1'b1; req0_op = 1'b0; req0_data = 16'h0100;
        req1_valid = 1'b1; req1_op = 1'b0; req1_data = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            #1;
            check("rr_ready0", req0_ready, !g);
            check("rr_ready1", req1_ready, g);
            check("rr_rsp0", rsp0_valid, k > 0 && g);
            check("rr_rsp1", rsp1_valid, k > 0 && !g);
            @(negedge clock);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            check("rr_exec_ready", {req0_ready, req1_ready}, 0);
            check("rr_push", stk_push, 1);
            check("rr_wdata", stk_write_data, g ? 16'h0200 : 16'h0100);
            @(negedge clock);
        end
        #1;
        check("rr_last_rsp1", rsp1_valid, 1);
        check("rr_last_rsp0", rsp0_valid, 0);
        check("rr_depth", depth, 4);
        check("rr_top", stk_read_data, 16'h0200);

        // Contention with last_grant = 0: requester 1 must win
        do_reset();
        do_op(1'b0, 1'b0, 16'h5555, 1'b0, 16'h0);
        @(negedge clock);
        req0_valid = 1'b1; req0_op = 1'b0; req0_data = 16'h7777;
        req1_valid = 1'b1; req1_op = 1'b1; req1_data = 16'h0;
        #1;
        check("ct_ready1", req1_ready, 1);
        check("ct_ready0", req0_ready, 0);
        @(negedge clock);
        req1_valid = 1'b0;
        #1;
        check("ct_pop", stk_pop, 1);
        @(negedge clock);
        #1;
        check("ct_rsp1_valid", rsp1_valid, 1);
        check("ct_rsp1_data", rsp1_data, 16'h5555);
        check("ct_ready0_late", req0_ready, 1);
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        check("ct_push", stk_push, 1);
        check("ct_wdata", stk_write_data, 16'h7777);
        @(negedge clock);
        #1;
        check("ct_rsp0_valid", rsp0_valid, 1);
        check("ct_depth", depth, 1);

        // Reset during EXEC abandons the op
        do_reset();
        @(negedge clock);
        req0_valid = 1'b1; req0_op = 1'b0; req0_data = 16'h9999;
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        check("mr_push_exec", stk_push, 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mr_push_drop", stk_push, 0);
        check("mr_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("mr_depth", depth, 0);
        check("mr_empty", empty, 1);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("mr_rsp_after", {rsp0_valid, rsp1_valid}, 0);
        do_op(1'b0, 1'b0, 16'h4321, 1'b0, 16'h0);
        check("mr_depth_after", depth, 1);
        check("mr_top", stk_read_data, 16'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
